fetch_sequencer: RTL and testbench

//  Sequences instruction fetch for the CPU: owns the architectural PC register, issues
//  req/ack reads to instruction memory, presents each fetched word with a valid/ready handshake,
//  and applies branch redirects from NextPC resolution. Sits between imem and decode.

---
 rtl/fetch_sequencer_if.sv | 25 ++
 rtl/fetch_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: the imem read port plus the decode-side valid/ready port.
// The master side is the fetch sequencer; the slave side is the imem/decode environment.
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned INSTR_W = 32
);
    logic               IMemReq;
    logic [ADDR_W-1:0]  IMemAddr;
    logic               IMemAck;
    logic [INSTR_W-1:0] IMemData;
    logic               InstrValid;
    logic [INSTR_W-1:0] Instr;
    logic [ADDR_W-1:0]  InstrPC;
    logic               InstrReady;

    modport master (
        output IMemReq, IMemAddr, InstrValid, Instr, InstrPC,
        input  IMemAck, IMemData, InstrReady
    );

    modport slave (
        input  IMemReq, IMemAddr, InstrValid, Instr, InstrPC,
        output IMemAck, IMemData, InstrReady
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues req/ack imem reads, hands each word to
// decode through a valid/ready handshake and applies branch redirects.
// Optional feature: define FETCH_COUNT_EN to add the FetchCount accept counter port.
module fetch_sequencer #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic [ADDR_W-1:0] StartPC,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectPC,
    fetch_sequencer_if.master fetch_if,
    output logic              FetchErr
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]       FetchCount
`endif
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StErr} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  ipc_q, ipc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               req_q, req_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               redir_pend_q, redir_pend_d;
    logic [31:0]        timer_q, timer_d;

    logic [ADDR_W-1:0]  redir_pc;
    logic               ack;
    logic               timeout_hit;

    assign redir_pc    = RedirectPC & ~ADDR_W'(3);
    assign ack         = fetch_if.IMemAck;
    // This cycle would be the TIMEOUT-th request cycle without an ack.
    assign timeout_hit = (TIMEOUT != 0) && ((timer_q + 32'd1) == 32'(TIMEOUT));

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state_q      <= StIdle;
            pc_q         <= StartPC & ~ADDR_W'(3);
            addr_q       <= '0;
            ipc_q        <= '0;
            instr_q      <= '0;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            redir_pend_q <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            ipc_q        <= ipc_d;
            instr_q      <= instr_d;
            req_q        <= req_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            redir_pend_q <= redir_pend_d;
            timer_q      <= timer_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: begin
                if (req_q && !ack && timeout_hit) begin
                    state_d = StErr;
                end else if (req_q && ack && !redir_pend_q && !Redirect) begin
                    state_d = StHold;
                end
            end
            StHold:  if (Redirect || fetch_if.InstrReady) state_d = StFetch;
            StErr:   state_d = StErr;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the PC and of every registered output.
    always_comb begin
        pc_d         = pc_q;
        addr_d       = addr_q;
        ipc_d        = ipc_q;
        instr_d      = instr_q;
        req_d        = req_q;
        valid_d      = valid_q;
        err_d        = err_q;
        redir_pend_d = redir_pend_q;
        timer_d      = timer_q;
        unique case (state_q)
            StIdle: begin
                req_d   = 1'b1;
                addr_d  = pc_q;
                timer_d = '0;
            end
            StFetch: begin
                if (!req_q) begin
                    // Re-issue after a dropped response; a redirect here retargets it directly.
                    req_d   = 1'b1;
                    timer_d = '0;
                    if (Redirect) begin
                        pc_d   = redir_pc;
                        addr_d = redir_pc;
                    end else begin
                        addr_d = pc_q;
                    end
                end else if (ack) begin
                    req_d        = 1'b0;
                    timer_d      = '0;
                    redir_pend_d = 1'b0;
                    if (redir_pend_q || Redirect) begin
                        // Stale response: drop it, the PC already (or now) holds the target.
                        if (Redirect) pc_d = redir_pc;
                    end else begin
                        instr_d = fetch_if.IMemData;
                        ipc_d   = pc_q;
                        pc_d    = pc_q + ADDR_W'(4);
                        valid_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    req_d = 1'b0;
                    err_d = 1'b1;
                end else begin
                    timer_d = timer_q + 32'd1;
                    // Request in flight cannot be aborted; remember to discard its data.
                    if (Redirect) begin
                        redir_pend_d = 1'b1;
                        pc_d         = redir_pc;
                    end
                end
            end
            StHold: begin
                if (Redirect) begin
                    valid_d = 1'b0;
                    pc_d    = redir_pc;
                    addr_d  = redir_pc;
                    req_d   = 1'b1;
                    timer_d = '0;
                end else if (fetch_if.InstrReady) begin
                    valid_d = 1'b0;
                    addr_d  = pc_q;
                    req_d   = 1'b1;
                    timer_d = '0;
                end
            end
            StErr: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
            default: ;
        endcase
    end

    assign fetch_if.IMemReq    = req_q;
    assign fetch_if.IMemAddr   = addr_q;
    assign fetch_if.InstrValid = valid_q;
    assign fetch_if.Instr      = instr_q;
    assign fetch_if.InstrPC    = ipc_q;
    assign FetchErr            = err_q;

`ifdef FETCH_COUNT_EN
    logic [31:0] count_q;

    // Saturating count of instructions accepted by decode.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            count_q <= '0;
        end else if (state_q == StHold && fetch_if.InstrReady && !Redirect &&
                     count_q != 32'hFFFF_FFFF) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign FetchCount = count_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios, then randomized imem latency, decode stalls
// and redirects checked against a transaction-level model of the expected PC stream.
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [63:0] StartPC;
    logic        Redirect;
    logic [63:0] RedirectPC;
    logic        FetchErr;
`ifdef FETCH_COUNT_EN
    logic [31:0] FetchCount;
`endif

    int checks = 0;
    int errors = 0;

    fetch_sequencer_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

    fetch_sequencer #(.ADDR_W(64), .INSTR_W(32), .TIMEOUT(16)) dut (
        .CLK        (CLK),
        .Reset_L    (Reset_L),
        .StartPC    (StartPC),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .fetch_if   (bus),
        .FetchErr   (FetchErr)
`ifdef FETCH_COUNT_EN
        ,
        .FetchCount (FetchCount)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Imem content: a unique word per address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[33:2] ^ 32'h5EED_1234;
    endfunction

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        t = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) t[63:6] = '1;  // near the wrap point
        return t;
    endfunction

    // Random-phase model state
    logic [63:0] exp_pc;
    logic [63:0] req_addr;
    logic [63:0] tgt;
    logic        exp_valid, pend, prev_req, prev_valid;
    int          delay, idle, accepts;

    initial begin
        Reset_L        = 1'b0;
        StartPC        = 64'h1003;
        Redirect       = 1'b0;
        RedirectPC     = '0;
        bus.IMemAck    = 1'b1;
        bus.IMemData   = 32'hDEAD_0001;
        bus.InstrReady = 1'b0;
        step();
        step();
        check("rst_req",   bus.IMemReq, 0);
        check("rst_addr",  bus.IMemAddr, 0);
        check("rst_valid", bus.InstrValid, 0);
        check("rst_instr", bus.Instr, 0);
        check("rst_ipc",   bus.InstrPC, 0);
        check("rst_err",   FetchErr, 0);

        // Immediate ack after release, StartPC low bits dropped
        Reset_L = 1'b1;
        step();
        check("t1_req",   bus.IMemReq, 1);
        check("t1_addr",  bus.IMemAddr, 64'h1000);
        check("t1_valid", bus.InstrValid, 0);
        step();
        check("t1_valid2", bus.InstrValid, 1);
        check("t1_ipc",    bus.InstrPC, 64'h1000);
        check("t1_instr",  bus.Instr, 32'hDEAD_0001);
        check("t1_reqlo",  bus.IMemReq, 0);
        bus.IMemAck    = 1'b0;
        bus.InstrReady = 1'b1;
        step();
        check("t1_next_addr", bus.IMemAddr, 64'h1004);
        check("t1_next_req",  bus.IMemReq, 1);
        check("t1_bubble",    bus.InstrValid, 0);

        // Slow imem, stalling decode
        bus.InstrReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_addr_hold", bus.IMemAddr, 64'h1004);
            check("t2_req_hold",  bus.IMemReq, 1);
            check("t2_no_valid",  bus.InstrValid, 0);
        end
        bus.IMemAck  = 1'b1;
        bus.IMemData = 32'hDEAD_0002;
        step();
        bus.IMemAck  = 1'b0;
        check("t2_valid", bus.InstrValid, 1);
        check("t2_ipc",   bus.InstrPC, 64'h1004);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_instr_hold", bus.Instr, 32'hDEAD_0002);
            check("t2_valid_hold", bus.InstrValid, 1);
            check("t2_no_dup",     bus.IMemReq, 0);
        end
        bus.InstrReady = 1'b1;
        step();
        bus.InstrReady = 1'b0;
        check("t2_next_addr", bus.IMemAddr, 64'h1008);

        // Redirect during FETCH at 0x1008; response two cycles later is dropped
        Redirect   = 1'b1;
        RedirectPC = 64'h3000;
        step();
        Redirect = 1'b0;
        check("t4_addr_kept", bus.IMemAddr, 64'h1008);
        step();
        bus.IMemAck  = 1'b1;
        bus.IMemData = 32'hBAD0_BAD0;
        step();
        bus.IMemAck = 1'b0;
        check("t4_dropped", bus.InstrValid, 0);
        check("t4_req_gap", bus.IMemReq, 0);
        step();
        check("t4_refetch_req",  bus.IMemReq, 1);
        check("t4_refetch_addr", bus.IMemAddr, 64'h3000);
        bus.IMemAck  = 1'b1;
        bus.IMemData = 32'hDEAD_0003;
        step();
        bus.IMemAck = 1'b0;
        check("t4_ipc", bus.InstrPC, 64'h3000);

        // Redirect in HOLD beats InstrReady; target low bits forced to zero
        Redirect       = 1'b1;
        RedirectPC     = 64'h2001;
        bus.InstrReady = 1'b1;
        step();
        Redirect       = 1'b0;
        bus.InstrReady = 1'b0;
        check("t3_dropped", bus.InstrValid, 0);
        check("t3_addr",    bus.IMemAddr, 64'h2000);

        // Wrap from the top of the address space (redirect coincident with ack)
        Redirect     = 1'b1;
        RedirectPC   = 64'hFFFF_FFFF_FFFF_FFFC;
        bus.IMemAck  = 1'b1;
        bus.IMemData = 32'hBAD0_BAD1;
        step();
        Redirect    = 1'b0;
        bus.IMemAck = 1'b0;
        check("t6_dropped", bus.InstrValid, 0);
        step();
        check("t6_top_addr", bus.IMemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
        bus.IMemAck  = 1'b1;
        bus.IMemData = 32'hDEAD_0004;
        step();
        bus.IMemAck    = 1'b0;
        bus.InstrReady = 1'b1;
        check("t6_ipc", bus.InstrPC, 64'hFFFF_FFFF_FFFF_FFFC);
        step();
        bus.InstrReady = 1'b0;
        check("t6_wrap_addr", bus.IMemAddr, 64'h0);
`ifdef FETCH_COUNT_EN
        check("t6_count", FetchCount, 3);
`endif

        // Timeout: 16 request cycles without ack
        for (int i = 0; i < 15; i++) step();
        check("t5_no_err_yet", FetchErr, 0);
        check("t5_req_yet",    bus.IMemReq, 1);
        step();
        check("t5_err",   FetchErr, 1);
        check("t5_reqlo", bus.IMemReq, 0);
        Redirect   = 1'b1;
        RedirectPC = 64'h4000;
        step();
        Redirect = 1'b0;
        check("t5_sticky", FetchErr, 1);
        check("t5_ignore_redirect", bus.IMemReq, 0);
        Reset_L = 1'b0;
        step();
        check("t5_reset_clears", FetchErr, 0);

        // Randomized phase
        StartPC = rand_target();
        step();
        Reset_L    = 1'b1;
        exp_pc     = StartPC & ~64'd3;
        exp_valid  = 1'b0;
        pend       = 1'b0;
        prev_req   = 1'b0;
        prev_valid = 1'b0;
        req_addr   = '0;
        delay      = 0;
        idle       = 0;
        accepts    = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            check("r_valid", bus.InstrValid, exp_valid);
            if (bus.InstrValid && !prev_valid) begin
                check("r_ipc",   bus.InstrPC, exp_pc);
                check("r_instr", bus.Instr, mem_word(exp_pc));
            end
            if (bus.IMemReq && !prev_req) begin
                check("r_req_addr", bus.IMemAddr, exp_pc);
                req_addr = bus.IMemAddr;
                delay    = $urandom_range(0, 5);
            end else if (bus.IMemReq) begin
                check("r_addr_hold", bus.IMemAddr, req_addr);
            end
            if (!bus.IMemReq && !bus.InstrValid) idle++;
            else idle = 0;
            if (idle > 2) check("r_stuck_idle", idle, 0);
            check("r_no_err", FetchErr, 0);

            prev_req       = bus.IMemReq;
            prev_valid     = bus.InstrValid;
            Redirect       = 1'b0;
            bus.IMemAck    = 1'b0;
            bus.InstrReady = 1'b0;
            if (bus.InstrValid) begin
                if ($urandom_range(0, 5) == 0) begin
                    tgt        = rand_target();
                    Redirect   = 1'b1;
                    RedirectPC = tgt;
                    exp_pc     = tgt & ~64'd3;
                    exp_valid  = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    bus.InstrReady = 1'b1;
                    exp_pc         = exp_pc + 64'd4;
                    exp_valid      = 1'b0;
                    accepts++;
                end
            end else if (bus.IMemReq) begin
                if (delay == 0) begin
                    bus.IMemAck  = 1'b1;
                    bus.IMemData = mem_word(bus.IMemAddr);
                    if ($urandom_range(0, 5) == 0) begin
                        tgt        = rand_target();
                        Redirect   = 1'b1;
                        RedirectPC = tgt;
                        exp_pc     = tgt & ~64'd3;
                        pend       = 1'b0;
                    end else if (pend) begin
                        pend = 1'b0;
                    end else begin
                        exp_valid = 1'b1;
                    end
                end else begin
                    delay--;
                    if ($urandom_range(0, 7) == 0) begin
                        tgt        = rand_target();
                        Redirect   = 1'b1;
                        RedirectPC = tgt;
                        exp_pc     = tgt & ~64'd3;
                        pend       = 1'b1;
                    end
                end
            end
            step();
        end
        Redirect       = 1'b0;
        bus.IMemAck    = 1'b0;
        bus.InstrReady = 1'b0;
`ifdef FETCH_COUNT_EN
        check("r_count", FetchCount, 32'(accepts));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
